// File: rtl/approx_add_pipe.sv
// approx_add_pipe
//   Two-stage pipelined lower-part-OR approximate adder. Each beat selects
//   exact or approximate addition. A built-in monitor reports each beat's
//   absolute error and accumulates saturating accuracy statistics.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   in_valid/ready  operand beat handshake
//   in_a, in_b      operands (WIDTH bits)
//   in_mode         0 = exact add, 1 = approximate add (sampled with operands)
//   out_valid/ready result beat handshake
//   out_sum         result, carry-out in MSB (WIDTH+1 bits)
//   out_err         |exact sum - out_sum| for this beat
//   stats_clr       synchronous clear of statistics (wins over a handshake)
//   stat_txn        completed output handshakes, saturating
//   stat_errs       completed beats with non-zero error, saturating
//   stat_max_err    largest out_err over completed beats
`timescale 1ns/1ps

module approx_add_pipe #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned APPROX_LSB = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic [WIDTH:0]   out_err,
    input  logic             stats_clr,
    output logic [CNT_W-1:0] stat_txn,
    output logic [CNT_W-1:0] stat_errs,
    output logic [WIDTH:0]   stat_max_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] a1, b1;
    logic             m1, v1;
    logic [WIDTH:0]   sum2, err2;
    logic             v2;

    logic             ld1, ld2, out_fire;
    logic [WIDTH:0]   exact_sum, approx_sum, res_sum, res_err;

    // Stage 2 advances when empty or drained; stage 1 advances when empty or
    // when stage 2 takes its contents. in_ready is therefore exactly ld1.
    assign ld2      = !v2 || out_ready;
    assign ld1      = !v1 || ld2;
    assign in_ready = ld1;
    assign out_fire = v2 && out_ready;

    assign out_valid = v2;
    assign out_sum   = sum2;
    assign out_err   = err2;

    assign exact_sum = {1'b0, a1} + {1'b0, b1};

    generate
        if (APPROX_LSB == 0) begin : g_exact_only
            assign approx_sum = exact_sum;
        end else begin : g_lopa
            localparam int unsigned K = APPROX_LSB;
            logic             carry;
            logic [WIDTH-K:0] upper;
            // Low part is a plain OR; the only carry into the exact upper part
            // is the AND of the top approximate bit pair.
            assign carry      = a1[K-1] & b1[K-1];
            assign upper      = {1'b0, a1[WIDTH-1:K]} + {1'b0, b1[WIDTH-1:K]}
                              + {{(WIDTH-K){1'b0}}, carry};
            assign approx_sum = {upper, a1[K-1:0] | b1[K-1:0]};
        end
    endgenerate

    always_comb begin
        res_sum = m1 ? approx_sum : exact_sum;
        // The approximation can overshoot (dropped-carry compensation) or
        // undershoot, so the error is a true absolute difference.
        if (res_sum >= exact_sum) begin
            res_err = res_sum - exact_sum;
        end else begin
            res_err = exact_sum - res_sum;
        end
    end

    // Stage 1 operands carry no reset; only their valid bit matters.
    always_ff @(posedge clk) begin
        if (ld1) begin
            a1 <= in_a;
            b1 <= in_b;
            m1 <= in_mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            v2   <= 1'b0;
            sum2 <= '0;
            err2 <= '0;
        end else begin
            if (ld1) begin
                v1 <= in_valid;
            end
            if (ld2) begin
                v2   <= v1;
                sum2 <= res_sum;
                err2 <= res_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_txn     <= '0;
            stat_errs    <= '0;
            stat_max_err <= '0;
        end else if (stats_clr) begin
            stat_txn     <= '0;
            stat_errs    <= '0;
            stat_max_err <= '0;
        end else if (out_fire) begin
            if (stat_txn != CNT_MAX) begin
                stat_txn <= stat_txn + 1'b1;
            end
            if ((err2 != '0) && (stat_errs != CNT_MAX)) begin
                stat_errs <= stat_errs + 1'b1;
            end
            if (err2 > stat_max_err) begin
                stat_max_err <= err2;
            end
        end
    end

endmodule

// File: tb/tb_approx_add_pipe.sv
// tb_approx_add_pipe
//   Directed bench for approx_add_pipe. Three instances share one stimulus:
//   the default configuration (k=4, 16-bit counters), a 3-bit-counter copy
//   for saturation, and a k=0 copy that must always be exact.
`timescale 1ns/1ps

module tb_approx_add_pipe;

    logic       clk = 1'b0;
    logic       rst_n, in_valid, in_mode, out_ready, stats_clr;
    logic [7:0] in_a, in_b;

    logic       d_in_ready, d_out_valid;
    logic [8:0] d_out_sum, d_out_err, d_stat_max_err;
    logic [15:0] d_stat_txn, d_stat_errs;

    logic       s_in_ready, s_out_valid;
    logic [8:0] s_out_sum, s_out_err, s_stat_max_err;
    logic [2:0] s_stat_txn, s_stat_errs;

    logic       e_in_ready, e_out_valid;
    logic [8:0] e_out_sum, e_out_err, e_stat_max_err;
    logic [15:0] e_stat_txn, e_stat_errs;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    approx_add_pipe #(.WIDTH(8), .APPROX_LSB(4), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(d_in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
        .out_valid(d_out_valid), .out_ready(out_ready),
        .out_sum(d_out_sum), .out_err(d_out_err), .stats_clr(stats_clr),
        .stat_txn(d_stat_txn), .stat_errs(d_stat_errs), .stat_max_err(d_stat_max_err)
    );

    approx_add_pipe #(.WIDTH(8), .APPROX_LSB(4), .CNT_W(3)) u_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_sum(s_out_sum), .out_err(s_out_err), .stats_clr(stats_clr),
        .stat_txn(s_stat_txn), .stat_errs(s_stat_errs), .stat_max_err(s_stat_max_err)
    );

    approx_add_pipe #(.WIDTH(8), .APPROX_LSB(0), .CNT_W(16)) u_exact (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(e_in_ready),
        .in_a(in_a), .in_b(in_b), .in_mode(in_mode),
        .out_valid(e_out_valid), .out_ready(out_ready),
        .out_sum(e_out_sum), .out_err(e_out_err), .stats_clr(stats_clr),
        .stat_txn(e_stat_txn), .stat_errs(e_stat_errs), .stat_max_err(e_stat_max_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic m);
        in_valid = v;
        in_a     = a;
        in_b     = b;
        in_mode  = m;
    endtask

    // Reference for k=4, WIDTH=8: {sum[8:0], err[8:0]}
    function automatic logic [17:0] model(input logic [7:0] a, input logic [7:0] b, input logic m);
        logic [8:0] ex, ap, er;
        ex = {1'b0, a} + {1'b0, b};
        if (!m) begin
            ap = ex;
        end else begin
            ap = '0;
            for (int i = 0; i < 4; i++) ap[i] = a[i] | b[i];
            ap[8:4] = {1'b0, a[7:4]} + {1'b0, b[7:4]} + {4'b0, a[3] & b[3]};
        end
        er = (ap > ex) ? ap - ex : ex - ap;
        return {ap, er};
    endfunction

    logic [7:0]  va [16];
    logic [7:0]  vb [16];
    logic [17:0] exp_q [$];
    logic [17:0] exp_v;
    logic [8:0]  held_sum, held_err;
    int          cyc, idx, n_out;
    logic        stale;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        va = '{8'h00, 8'h0F, 8'h08, 8'hFF, 8'h37, 8'hA5, 8'h5A, 8'h99,
               8'h80, 8'h7F, 8'h12, 8'hC3, 8'h3C, 8'hE1, 8'h6B, 8'hF0};
        vb = '{8'h00, 8'h01, 8'h08, 8'hFF, 8'h48, 8'h5A, 8'hA5, 8'h66,
               8'h80, 8'h01, 8'hED, 8'h3C, 8'hC3, 8'h1F, 8'h94, 8'h0F};

        rst_n = 1'b1; stats_clr = 1'b0; out_ready = 1'b1;
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        #1 rst_n = 1'b0;
        #2;
        check("rst_out_valid", d_out_valid, 0);
        check("rst_out_sum", d_out_sum, 0);
        check("rst_out_err", d_out_err, 0);
        check("rst_stat_txn", d_stat_txn, 0);
        check("rst_stat_errs", d_stat_errs, 0);
        check("rst_stat_max", d_stat_max_err, 0);
        check("rst_in_ready", d_in_ready, 1);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", d_in_ready, 1);

        // Scenario 1: approximate beats, 2-cycle latency
        drive(1'b1, 8'h0F, 8'h01, 1'b1);
        tick();
        check("lat_not_early", d_out_valid, 0);
        drive(1'b1, 8'h08, 8'h08, 1'b1);
        tick();
        check("s1a_valid", d_out_valid, 1);
        check("s1a_sum", d_out_sum, 9'h00F);
        check("s1a_err", d_out_err, 9'h001);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        check("s1b_valid", d_out_valid, 1);
        check("s1b_sum", d_out_sum, 9'h018);
        check("s1b_err", d_out_err, 9'h008);

        // Scenario 2: exact then approximate, back to back
        drive(1'b1, 8'hFF, 8'hFF, 1'b0);
        tick();
        check("s2_gap_valid", d_out_valid, 0);
        drive(1'b1, 8'hFF, 8'hFF, 1'b1);
        tick();
        check("s2a_sum", d_out_sum, 9'h1FE);
        check("s2a_err", d_out_err, 9'h000);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        check("s2b_sum", d_out_sum, 9'h1FF);
        check("s2b_err", d_out_err, 9'h001);
        tick();
        check("s2_drained", d_out_valid, 0);

        // Scenario 4: statistics from the four beats above, then clear
        check("st_txn", d_stat_txn, 4);
        check("st_errs", d_stat_errs, 3);
        check("st_max", d_stat_max_err, 8);
        drive(1'b1, 8'h0F, 8'h01, 1'b1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        check("clr_pre_valid", d_out_valid, 1);
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        check("clr_txn", d_stat_txn, 0);
        check("clr_errs", d_stat_errs, 0);
        check("clr_max", d_stat_max_err, 0);
        check("clr_beat_consumed", d_out_valid, 0);

        // Scenario 3: 16-beat stream with a 5-cycle output stall
        cyc = 0; idx = 0; n_out = 0;
        while ((idx < 16 || exp_q.size() != 0) && cyc < 200) begin
            if (idx < 16) drive(1'b1, va[idx], vb[idx], idx[0]);
            else          drive(1'b0, 8'h00, 8'h00, 1'b0);
            out_ready = !(cyc >= 6 && cyc < 11);
            #1;
            if (cyc == 6) begin
                held_sum = d_out_sum;
                held_err = d_out_err;
            end
            if (cyc >= 6 && cyc < 11) begin
                check("stall_valid", d_out_valid, 1);
                check("stall_in_ready", d_in_ready, 0);
                check("stall_sum_hold", d_out_sum, held_sum);
                check("stall_err_hold", d_out_err, held_err);
            end
            if (in_valid && d_in_ready) begin
                exp_q.push_back(model(in_a, in_b, in_mode));
                idx++;
            end
            if (d_out_valid && out_ready) begin
                check("sb_expected_beat", (exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    exp_v = exp_q.pop_front();
                    check("sb_sum", d_out_sum, exp_v[17:9]);
                    check("sb_err", d_out_err, exp_v[8:0]);
                end
                n_out++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        out_ready = 1'b1;
        check("sb_in_time", (cyc < 200), 1);
        check("sb_count", n_out, 16);
        tick();
        check("sb_no_dup", d_out_valid, 0);

        // Scenario 5: saturation with 3-bit counters
        stats_clr = 1'b1;
        tick();
        stats_clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 8'h0F, 8'h01, 1'b1);
            tick();
        end
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        repeat (3) tick();
        check("sat_txn", s_stat_txn, 7);
        check("sat_errs", s_stat_errs, 7);
        check("sat_max", s_stat_max_err, 1);
        check("wide_txn", d_stat_txn, 10);
        check("wide_errs", d_stat_errs, 10);
        check("exact_errs", e_stat_errs, 0);

        // Scenario 6: asynchronous reset with two beats in flight
        out_ready = 1'b0;
        drive(1'b1, 8'h0F, 8'h01, 1'b1);
        tick();
        drive(1'b1, 8'h08, 8'h08, 1'b1);
        tick();
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        check("inflight_valid", d_out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_valid", d_out_valid, 0);
        check("arst_sum", d_out_sum, 0);
        check("arst_err", d_out_err, 0);
        check("arst_in_ready", d_in_ready, 1);
        tick();
        #2 rst_n = 1'b1;
        out_ready = 1'b1;
        stale = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            stale = stale | d_out_valid;
        end
        check("no_stale_beat", stale, 0);
        check("arst_stat_txn", d_stat_txn, 0);

        // Scenario 1 again, k=0 instance alongside k=4
        drive(1'b1, 8'h0F, 8'h01, 1'b1);
        tick();
        drive(1'b1, 8'h08, 8'h08, 1'b1);
        tick();
        check("k0a_sum", e_out_sum, 9'h010);
        check("k0a_err", e_out_err, 0);
        check("k4a_sum", d_out_sum, 9'h00F);
        drive(1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        check("k0b_valid", e_out_valid, 1);
        check("k0b_sum", e_out_sum, 9'h010);
        check("k0b_err", e_out_err, 0);
        check("k4b_err", d_out_err, 9'h008);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/approx_add_pipe.md
Name: approx_add_pipe

Overview:
- Parametrised, pipelined lower-part-OR approximate adder with a runtime exact/approximate mode per transaction.
- Valid/ready handshake on both sides.
- A built-in error monitor compares each result against the exact sum and accumulates statistics (transaction count, erroneous-result count, worst-case error).
- Serves as the reusable datapath adder for accelerator pipelines and as an on-chip accuracy probe for the approximate adder library.

Parameters:
WIDTH, 8, operand width in bits (>=2).
APPROX_LSB, 4, number of low bits computed approximately (0..WIDTH-1); 0 means the adder is always exact.
CNT_W, 16, width of the saturating statistics counters.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operand beat valid.
in_ready  out  1  block can accept operand beat.
in_a  in  WIDTH  operand A.
in_b  in  WIDTH  operand B.
in_mode  in  1  0 = exact add, 1 = approximate add.
out_valid  out  1  result beat valid.
out_ready  in  1  downstream accepts result.
out_sum  out  WIDTH+1  result (carry-out in MSB).
out_err  out  WIDTH+1  |exact sum - out_sum| for this beat.
stats_clr  in  1  synchronous clear of statistics.
stat_txn  out  CNT_W  completed output handshakes, saturating.
stat_errs  out  CNT_W  completed beats with out_err != 0, saturating.
stat_max_err  out  WIDTH+1  maximum out_err over completed beats.

Behaviour:
- Approximate arithmetic, with k = APPROX_LSB:
  - sum[i] = a[i] | b[i] for i < k.
  - c = a[k-1] & b[k-1].
  - sum[WIDTH:k] = a[WIDTH-1:k] + b[WIDTH-1:k] + c.
- k = 0 or in_mode = 0: sum = a + b (exact, WIDTH+1 bits).
- Error computation:
  - Exact sum is always computed in parallel.
  - out_err = absolute difference, unsigned WIDTH+1 bits.
  - out_err is 0 in exact mode.
- Pipeline structure:
  - Stage 1 registers a, b, mode, valid (v1).
  - Stage 2 registers sum, err, valid (v2).
  - Outputs are driven directly from stage-2 registers.
- Flow control:
  - Stage 2 loads when !v2 || out_ready.
  - Stage 1 loads when !v1 || stage 2 loads.
  - in_ready = !v1 || !v2 || out_ready. The combinational path out_ready -> in_ready is permitted.
- Latency and throughput:
  - Latency is 2 cycles from input handshake to out_valid with no stall.
  - Throughput is 1 beat/cycle.
  - No beat is dropped or duplicated under any out_ready pattern.
- While out_valid=1 && out_ready=0, out_sum and out_err hold stable.
- Mode is sampled with its operands; changing in_mode between beats never affects beats already accepted.
- Statistics update only on an output handshake (out_valid && out_ready):
  - stat_txn += 1.
  - stat_errs += 1 if out_err != 0.
  - stat_max_err = max(stat_max_err, out_err).
  - Counters saturate at 2^CNT_W-1 and never wrap.
- stats_clr has priority: when asserted in the same cycle as a handshake, all statistics become 0 and that beat is not counted. The pipeline is unaffected by stats_clr.
- Reset:
  - rst_n low forces v1 = v2 = 0 immediately (asynchronously).
  - Reset values: out_valid=0, out_sum=0, out_err=0, stat_txn=0, stat_errs=0, stat_max_err=0.
  - in_ready reads 1 during and after reset.
  - Reset mid-stream discards all in-flight beats.
  - Operand/data registers may be left without reset, but out_sum/out_err must read 0 after reset.

Test Plan:
1. WIDTH=8, k=4, mode=1:
   - a=0x0F, b=0x01 -> out_sum=0x00F, out_err=1.
   - a=0x08, b=0x08 -> out_sum=0x018, out_err=8.
   - Each appears exactly 2 cycles after the input handshake.
2. mode=0, a=0xFF, b=0xFF -> out_sum=0x1FE, out_err=0. Then mode=1 with the same operands -> out_sum=0x1FF, out_err=1, with modes interleaved back-to-back.
3. Stream 16 random beats with out_ready held 0 for 5 cycles mid-stream:
   - in_ready drops after 2 beats are buffered.
   - Output order and values match the model, with no loss or duplication.
   - Outputs stay stable during the stall.
4. Statistics, using the beats from scenarios 1 and 2: stat_txn=4, stat_errs=3, stat_max_err=8. Then assert stats_clr coincident with a handshake -> all statistics are 0 the next cycle.
5. CNT_W=3, 10 erroneous beats -> stat_txn=7 and stat_errs=7 (saturated, no wrap).
6. Assert rst_n low asynchronously with 2 beats in flight -> out_valid falls immediately with no clock edge, and no stale beat emerges after release. Repeat scenario 1 with k=0 -> all out_err=0.
